// File: rtl/aes256_key_sched_ctrl.sv
// aes256_key_sched_ctrl
//   Sequencing controller for the AES-256 key-expansion datapath. Accepts a
//   256-bit cipher key, kicks the expansion engine, stores the NR+1 streamed
//   round keys and serves registered random-access reads once the schedule
//   is complete. An engine that goes quiet for TIMEOUT cycles aborts the
//   expansion and raises the sticky kx_err.
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous reset, active low
//     key_in        cipher key offered on key_valid
//     key_valid     key offer
//     key_ready     key can be accepted (IDLE or READY)
//     kx_key        key held stable for the expansion engine
//     kx_start      one-cycle start pulse to the engine
//     kx_round_key  round key streamed from the engine, in order 0..NR
//     kx_valid      kx_round_key valid this cycle
//     rk_rd         round-key read request
//     rk_idx        requested round index
//     rk_data       read data, one cycle after the request
//     rk_vld        rk_data holds an accepted read
//     sched_valid   full schedule stored and servable
//     kx_err        sticky expansion timeout, cleared by the next key accept
module aes256_key_sched_ctrl #(
   parameter int NR      = 14,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [255:0] kx_key,
   output logic         kx_start,
   input  logic [127:0] kx_round_key,
   input  logic         kx_valid,
   input  logic         rk_rd,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data,
   output logic         rk_vld,
   output logic         sched_valid,
   output logic         kx_err
);

   localparam int              TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0]      LAST_IDX = 4'(NR);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } state_t;

   state_t          state;
   logic [3:0]      wr_cnt;
   logic [TO_W-1:0] to_cnt;
   logic [127:0]    slot [NR+1];

   logic accept;
   logic wr_en;
   logic rd_ok;

   always_comb begin
      accept = key_valid && (state != EXPAND);
      wr_en  = (state == EXPAND) && kx_valid;
      // sched_valid is still low on the edge of the last write, so a read in
      // that cycle is rejected; a read alongside a re-key uses the old slots.
      rd_ok  = rk_rd && sched_valid && (rk_idx <= LAST_IDX);
   end

   // Slot contents need no reset; writes are gated by the reset state.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         slot[wr_cnt] <= kx_round_key;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         key_ready   <= 1'b1;
         kx_key      <= '0;
         kx_start    <= 1'b0;
         rk_data     <= '0;
         rk_vld      <= 1'b0;
         sched_valid <= 1'b0;
         kx_err      <= 1'b0;
         wr_cnt      <= '0;
         to_cnt      <= '0;
      end else begin
         kx_start <= 1'b0;
         rk_vld   <= rd_ok;
         rk_data  <= rd_ok ? slot[rk_idx] : '0;

         case (state)
            IDLE, READY: begin
               if (accept) begin
                  kx_key      <= key_in;
                  kx_start    <= 1'b1;
                  kx_err      <= 1'b0;
                  wr_cnt      <= '0;
                  to_cnt      <= '0;
                  sched_valid <= 1'b0;
                  key_ready   <= 1'b0;
                  state       <= EXPAND;
               end
            end

            EXPAND: begin
               if (kx_valid) begin
                  to_cnt <= '0;
                  if (wr_cnt == LAST_IDX) begin
                     sched_valid <= 1'b1;
                     key_ready   <= 1'b1;
                     state       <= READY;
                  end else begin
                     wr_cnt <= wr_cnt + 4'd1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  // TIMEOUT quiet edges in a row: abandon the partial schedule.
                  kx_err    <= 1'b1;
                  key_ready <= 1'b1;
                  state     <= IDLE;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            default: begin
               key_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
module tb_aes256_key_sched_ctrl;

   localparam int NR      = 14;
   localparam int TIMEOUT = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic [255:0] kx_key;
   logic         kx_start;
   logic [127:0] kx_round_key;
   logic         kx_valid;
   logic         rk_rd;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         rk_vld;
   logic         sched_valid;
   logic         kx_err;

   aes256_key_sched_ctrl #(
      .NR      (NR),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .kx_key       (kx_key),
      .kx_start     (kx_start),
      .kx_round_key (kx_round_key),
      .kx_valid     (kx_valid),
      .rk_rd        (rk_rd),
      .rk_idx       (rk_idx),
      .rk_data      (rk_data),
      .rk_vld       (rk_vld),
      .sched_valid  (sched_valid),
      .kx_err       (kx_err)
   );

   always #5 clk = ~clk;

   int n_cmp       = 0;
   int n_bad       = 0;
   int starts_seen = 0;
   int starts_exp  = 0;

   // Reference model: what the schedule should hold and whether it is servable.
   logic [127:0] exp_slot [NR+1];
   logic         exp_sv;

   always @(negedge clk) begin
      if (kx_start === 1'b1) starts_seen++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no end of test, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Expected {rk_vld, rk_data} for a read issued now.
   function automatic logic [128:0] read_exp(input logic [3:0] idx);
      if (exp_sv && int'(idx) <= NR) return {1'b1, exp_slot[idx]};
      return '0;
   endfunction

   task automatic chk_reset(input string pfx);
      chk({pfx, "_key_ready"},   256'(key_ready),   256'(1'b1));
      chk({pfx, "_kx_start"},    256'(kx_start),    256'(1'b0));
      chk({pfx, "_kx_key"},      kx_key,            256'(0));
      chk({pfx, "_rk_data"},     256'(rk_data),     256'(0));
      chk({pfx, "_rk_vld"},      256'(rk_vld),      256'(1'b0));
      chk({pfx, "_sched_valid"}, 256'(sched_valid), 256'(1'b0));
      chk({pfx, "_kx_err"},      256'(kx_err),      256'(1'b0));
   endtask

   task automatic do_read(input logic [3:0] idx);
      logic [128:0] e;
      e      = read_exp(idx);
      rk_rd  = 1'b1;
      rk_idx = idx;
      tick();
      rk_rd  = 1'b0;
      chk($sformatf("read_idx%0d", idx), 256'({rk_vld, rk_data}), 256'(e));
   endtask

   // Key accept, optionally with a read in the same cycle; leaves time one
   // cycle after the kx_start pulse.
   task automatic accept(input logic [255:0] k, input logic rd, input logic [3:0] idx);
      logic [128:0] e;
      e         = read_exp(idx);
      key_in    = k;
      key_valid = 1'b1;
      rk_rd     = rd;
      rk_idx    = idx;
      tick();
      key_valid = 1'b0;
      rk_rd     = 1'b0;
      starts_exp++;
      exp_sv    = 1'b0;
      if (rd) chk("accept_read", 256'({rk_vld, rk_data}), 256'(e));
      chk("accept_kx_start",    256'(kx_start),    256'(1'b1));
      chk("accept_kx_key",      kx_key,            k);
      chk("accept_key_ready",   256'(key_ready),   256'(1'b0));
      chk("accept_sched_valid", 256'(sched_valid), 256'(1'b0));
      chk("accept_kx_err",      256'(kx_err),      256'(1'b0));
      tick();
      chk("start_single_pulse", 256'(kx_start),    256'(1'b0));
   endtask

   // Model engine: n round keys with random gaps up to max_gap; a random
   // read is issued every cycle and must be rejected while expanding.
   task automatic stream(input int n, input int max_gap);
      int gap;
      for (int i = 0; i < n; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g <= gap; g++) begin
            kx_valid = (g == gap);
            if (g == gap) begin
               kx_round_key = rnd128();
               exp_slot[i]  = kx_round_key;
            end
            rk_rd  = 1'b1;
            rk_idx = 4'($urandom_range(0, 15));
            tick();
            rk_rd    = 1'b0;
            kx_valid = 1'b0;
            chk("expand_read", 256'({rk_vld, rk_data}), 256'(0));
            if (i != NR || g != gap)
               chk("expand_sched_low", 256'(sched_valid), 256'(1'b0));
         end
      end
   endtask

   task automatic chk_ready(input logic [255:0] k);
      exp_sv = 1'b1;
      chk("ready_sched_valid", 256'(sched_valid), 256'(1'b1));
      chk("ready_key_ready",   256'(key_ready),   256'(1'b1));
      chk("ready_kx_err",      256'(kx_err),      256'(1'b0));
      chk("ready_kx_key",      kx_key,            k);
   endtask

   initial begin
      logic [255:0] k1, k2, k3, k4, k5;
      k1 = 256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
      k2 = {rnd128(), rnd128()};
      k3 = {rnd128(), rnd128()};
      k4 = {rnd128(), rnd128()};
      k5 = {rnd128(), rnd128()};

      rst = 1'b0; key_in = '0; key_valid = 1'b0; kx_round_key = '0;
      kx_valid = 1'b0; rk_rd = 1'b0; rk_idx = '0; exp_sv = 1'b0;
      repeat (2) tick();
      chk_reset("reset");
      rst = 1'b1;
      tick();

      // Known key, back-to-back engine: sched_valid NR+2 cycles after accept.
      accept(k1, 1'b0, 4'd0);
      stream(NR + 1, 0);
      chk_ready(k1);
      for (int i = 0; i <= 15; i++) do_read(4'(i));

      // Read of slot 3 together with a re-key, then a gappy engine.
      accept(k2, 1'b1, 4'd3);
      stream(NR + 1, 40);
      chk_ready(k2);
      for (int i = 15; i >= 0; i--) do_read(4'(i));

      // Engine stalls after 5 keys.
      accept(k3, 1'b0, 4'd0);
      stream(5, 0);
      repeat (TIMEOUT - 1) tick();
      chk("stall_err_early",   256'(kx_err),    256'(1'b0));
      chk("stall_busy",        256'(key_ready), 256'(1'b0));
      tick();
      chk("stall_kx_err",      256'(kx_err),      256'(1'b1));
      chk("stall_key_ready",   256'(key_ready),   256'(1'b1));
      chk("stall_sched_valid", 256'(sched_valid), 256'(1'b0));
      do_read(4'd2);
      kx_round_key = rnd128();
      kx_valid     = 1'b1;
      tick();
      kx_valid     = 1'b0;
      chk("idle_kxv_key_ready", 256'(key_ready),   256'(1'b1));
      chk("idle_kxv_sched",     256'(sched_valid), 256'(1'b0));
      chk("idle_kxv_err_stick", 256'(kx_err),      256'(1'b1));

      // Recovery with a fresh key clears the error.
      accept(k4, 1'b0, 4'd0);
      stream(NR + 1, 0);
      chk_ready(k4);
      do_read(4'd5);
      do_read(4'd14);

      // Asynchronous reset between edges mid-expansion.
      accept(k5, 1'b0, 4'd0);
      stream(7, 0);
      #2;
      rst = 1'b0;
      #1;
      exp_sv = 1'b0;
      chk_reset("async");
      @(negedge clk);
      rst          = 1'b1;
      kx_round_key = rnd128();
      kx_valid     = 1'b1;
      tick();
      kx_valid     = 1'b0;
      chk("post_rst_key_ready", 256'(key_ready),   256'(1'b1));
      chk("post_rst_sched",     256'(sched_valid), 256'(1'b0));
      chk("post_rst_kx_start",  256'(kx_start),    256'(1'b0));
      do_read(4'd0);
      tick();
      chk("kx_start_pulses", 256'(starts_seen), 256'(starts_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes256_key_sched_ctrl.md
# aes256_key_sched_ctrl

Sequencing controller for the AES-256 key-expansion datapath in the AES-256-CTR core. It accepts a 256-bit cipher key over a valid/ready handshake, starts the expansion engine, and captures the 15 streamed 128-bit round keys into a local register file. Once the schedule is complete, it serves random-access round-key reads to the round pipeline. It also owns re-keying and expansion-timeout recovery, so the cipher never consumes a partial schedule.

## Interface
- NR, 14, last round index; the block stores NR+1 round keys (indices 0..NR).
- TIMEOUT, 64, maximum cycles between consecutive kx_valid pulses before EXPAND aborts.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_in  input  256  cipher key.
- key_valid  input  1  key_in offered.
- key_ready  output  1  controller can accept a key (IDLE or READY).
- kx_key  output  256  key held stable for the expansion engine.
- kx_start  output  1  one-cycle start pulse to the expansion engine.
- kx_round_key  input  128  round key streamed from the engine.
- kx_valid  input  1  kx_round_key valid this cycle, in order 0..NR.
- rk_rd  input  1  round-key read request.
- rk_idx  input  4  requested round index.
- rk_data  output  128  read data, registered.
- rk_vld  output  1  rk_data valid; asserted one cycle after an accepted read.
- sched_valid  output  1  full schedule stored and servable.
- kx_err  output  1  sticky; set on expansion timeout, cleared by the next key accept.

## Operation
- States: IDLE, EXPAND, READY.
- IDLE:
  - key_ready=1, sched_valid=0.
  - On key_valid&&key_ready: latch key_in into kx_key, assert kx_start for exactly one cycle, clear kx_err, set wr_cnt=0 and to_cnt=0, then go to EXPAND.
- EXPAND:
  - key_ready=0; key_valid is ignored and no handshake completes.
  - Each cycle with kx_valid: write kx_round_key into slot wr_cnt, increment wr_cnt, clear to_cnt.
  - On the write where wr_cnt==NR: go to READY and set sched_valid=1 on the next cycle.
  - Each cycle without kx_valid: increment to_cnt. If to_cnt reaches TIMEOUT-1 with kx_valid still low, set kx_err=1 and go to IDLE. Stored slots are not cleared, but sched_valid stays 0.
  - kx_valid seen in IDLE or READY is ignored and causes no write.
- READY:
  - key_ready=1, sched_valid=1.
  - A new key accept behaves as in IDLE: sched_valid drops to 0 on the same edge that enters EXPAND, and kx_start pulses.
- Reads:
  - A read is accepted when rk_rd&&sched_valid&&rk_idx<=NR. The next cycle, rk_data=slot[rk_idx] and rk_vld=1.
  - Any other rk_rd (schedule not valid, or idx>NR) gives rk_vld=0 and rk_data=0 the next cycle; nothing is stalled.
  - Reads may issue every cycle and have no ready signal.
- Simultaneous events:
  - A read and a key accept in the same READY cycle: the read is serviced from the old schedule (rk_vld=1 next cycle), then sched_valid falls.
  - kx_valid on the last write together with rk_rd in that same cycle: the read is rejected because sched_valid is still 0.
- Width rules: wr_cnt is 4 bits and never exceeds NR. to_cnt is sized ceil(log2(TIMEOUT)) bits and saturates, so it never wraps.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, key_ready=1, kx_start=0, kx_key=0, rk_data=0, rk_vld=0, sched_valid=0, kx_err=0, and both counters 0. Slot contents are don't-care.
- Reset asserted during EXPAND aborts immediately with no kx_err. The engine is restarted only by a new kx_start.
- Latencies:
  - Key accept to kx_start: kx_start is high in the cycle after the accepting edge.
  - Last kx_valid to sched_valid=1: 1 cycle.
  - rk_rd to rk_vld/rk_data: 1 cycle.
  - Minimum key-accept to sched_valid: NR+2 cycles, when the engine streams back-to-back.
- Between kx_start pulses, kx_key changes only at a key accept.

## Test plan
- Reset then key 642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30 with a model engine streaming 15 back-to-back keys -> single kx_start pulse, sched_valid high NR+2 cycles after accept, reads of idx 0..14 return the streamed words in order with rk_vld=1.
- Engine with random gaps under TIMEOUT between kx_valid pulses -> schedule completes and kx_err=0.
- Engine stalls after 5 keys -> kx_err=1 exactly TIMEOUT cycles after the 5th key, state IDLE, key_ready=1, sched_valid=0, reads return rk_vld=0.
- Reads with rk_idx=15, and reads during EXPAND -> rk_vld=0 and rk_data=0 the next cycle.
- In READY, a read of idx 3 and a new key accept in the same cycle -> old slot 3 is returned with rk_vld=1, sched_valid=0 the next cycle, kx_start pulses once, and the new schedule overwrites all slots.
- rst driven low asynchronously mid-EXPAND (between clock edges) -> all outputs take reset values immediately, and no write occurs on the next kx_valid.
